// File: rtl/ct_spsram_init_wrap.sv
// ct_spsram_init_wrap: single-port SRAM wrapper with a hardware init sequencer,
// a read-data hold register and an optional output register stage.
module tc_sram #(
   parameter int unsigned NumWords  = 256,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned NumPorts  = 1,
   parameter int unsigned Latency   = 1,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth   = DataWidth / ByteWidth
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumPorts-1:0]                 req_i,
   input  logic [NumPorts-1:0]                 we_i,
   input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
   input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
   output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);
   logic [DataWidth-1:0] mem_q [NumWords];
   logic [NumPorts-1:0][Latency-1:0][DataWidth-1:0] rd_q;
   always_ff @(posedge clk_i)
      for (int p = 0; p < NumPorts; p++)
         if (req_i[p] && we_i[p])
            for (int b = 0; b < BeWidth; b++)
               if (be_i[p][b]) mem_q[addr_i[p]][b*ByteWidth +: ByteWidth] <= wdata_i[p][b*ByteWidth +: ByteWidth];
   // read data only changes on a read, then ripples through Latency stages
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) rd_q <= '0;
      else
         for (int p = 0; p < NumPorts; p++) begin
            if (req_i[p] && !we_i[p]) rd_q[p][0] <= mem_q[addr_i[p]];
            for (int s = 1; s < Latency; s++) rd_q[p][s] <= rd_q[p][s-1];
         end
   for (genvar g = 0; g < NumPorts; g++) begin : g_rd
      assign rdata_o[g] = rd_q[g][Latency-1];
   end
endmodule

module ct_spsram_init_wrap #(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DATA_WIDTH = 23,
   parameter int unsigned           WE_WIDTH   = 23,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}},
   parameter bit                    OUT_REG    = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [WE_WIDTH-1:0]   WEN,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  INIT_REQ,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_BUSY
);
   localparam int unsigned L = DATA_WIDTH / WE_WIDTH;
   typedef enum logic {IDLE, INIT} state_e;
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, sram_addr;
   logic                  rd_vld_q, rd_vld_d, init, sram_req, sram_we;
   logic [DATA_WIDTH-1:0] q_hold_q, q_hold_d, sram_wdata, sram_rdata;
   logic [WE_WIDTH-1:0]   sram_be;
   assign init      = state_q == INIT;
   assign INIT_BUSY = init;
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (init) begin
         cnt_d = cnt_q + 1'b1;
         if (&cnt_q) state_d = IDLE;
      end else if (INIT_REQ) state_d = INIT;
   end
   // the sequencer owns the array port while busy; user inputs are masked off
   always_comb begin
      sram_req   = init | ~CEN;
      sram_we    = init | ~GWEN;
      sram_addr  = init ? cnt_q : A;
      sram_wdata = init ? INIT_VALUE : D;
      sram_be    = init ? '1 : ~WEN;
      rd_vld_d   = !init && !CEN && GWEN;
      q_hold_d   = rd_vld_q ? sram_rdata : q_hold_q;
      Q          = (OUT_REG || !rd_vld_q) ? q_hold_q : sram_rdata;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         rd_vld_q <= 1'b0;
         q_hold_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_vld_q <= rd_vld_d;
         q_hold_q <= q_hold_d;
      end
   tc_sram #(
      .NumWords (2**ADDR_WIDTH),
      .DataWidth(DATA_WIDTH),
      .ByteWidth(L),
      .NumPorts (1),
      .Latency  (1)
   ) u_sram (
      .clk_i  (CLK),
      .rst_ni (~RST),
      .req_i  (sram_req),
      .we_i   (sram_we),
      .addr_i (sram_addr),
      .wdata_i(sram_wdata),
      .be_i   (sram_be),
      .rdata_o(sram_rdata)
   );
endmodule

// File: tb/tb_ct_spsram_init_wrap.sv
// tb_ct_spsram_init_wrap: checks init sequencing, masked writes, Q hold and the output register option.
module tb_ct_spsram_init_wrap;
   localparam logic [22:0] IV0 = 23'h5A5A5;
   localparam logic [63:0] IV1 = 64'hDEAD_BEEF_0123_4567;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst0, cen0, gwen0, init_req0, busy0;
   logic [7:0]  a0;
   logic [22:0] wen0, d0, q0;
   logic        rst1, cen1, gwen1, init_req1, busy1;
   logic [3:0]  a1;
   logic [7:0]  wen1;
   logic [63:0] d1, q1;
   int total = 0, passed = 0;
   logic [22:0] mem0 [256];
   logic [22:0] exp0;
   logic [63:0] mem1 [16];

   ct_spsram_init_wrap #(.ADDR_WIDTH(8), .DATA_WIDTH(23), .WE_WIDTH(23), .INIT_VALUE(IV0), .OUT_REG(1'b0)) dut0 (
      .CLK(clk), .RST(rst0), .A(a0), .CEN(cen0), .GWEN(gwen0), .WEN(wen0), .D(d0),
      .INIT_REQ(init_req0), .Q(q0), .INIT_BUSY(busy0));
   ct_spsram_init_wrap #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .WE_WIDTH(8), .INIT_VALUE(IV1), .OUT_REG(1'b1)) dut1 (
      .CLK(clk), .RST(rst1), .A(a1), .CEN(cen1), .GWEN(gwen1), .WEN(wen1), .D(d1),
      .INIT_REQ(init_req1), .Q(q1), .INIT_BUSY(busy1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one user cycle on dut0 while idle; the model applies the same access
   task automatic op0(input logic c, input logic g, input logic [7:0] a, input logic [22:0] d, input logic [22:0] w);
      cen0 = c; gwen0 = g; a0 = a; d0 = d; wen0 = w;
      step();
      cen0 = 1'b1; gwen0 = 1'b1;
      if (!c && !g) mem0[a] = (mem0[a] & w) | (d & ~w);
      if (!c && g) exp0 = mem0[a];
   endtask

   task automatic op1(input logic c, input logic g, input logic [3:0] a, input logic [63:0] d, input logic [7:0] w);
      logic [63:0] m;
      for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{~w[k]}};
      cen1 = c; gwen1 = g; a1 = a; d1 = d; wen1 = w;
      step();
      cen1 = 1'b1; gwen1 = 1'b1;
      if (!c && !g) mem1[a] = (mem1[a] & ~m) | (d & m);
   endtask

   task automatic wait_init(input bit which, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while ((which ? busy1 : busy0) && n < 1000);
   endtask

   task automatic test_reset();
      int n;
      rst0 = 1'b1;
      step(); step();
      total++; if (q0 !== 23'h0) $display("FAIL reset_q: got %h want 0", q0); else passed++;
      total++; if (busy0 !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy0); else passed++;
      rst0 = 1'b0;
      total++; if (busy0 !== 1'b1) $display("FAIL busy_after_release: got %b want 1", busy0); else passed++;
      wait_init(1'b0, n);
      total++; if (n != 256) $display("FAIL init_len: got %0d want 256", n); else passed++;
      for (int i = 0; i < 256; i++) mem0[i] = IV0;
      exp0 = '0;
      total++; if (q0 !== 23'h0) $display("FAIL q_after_init: got %h want 0", q0); else passed++;
      op0(1'b0, 1'b1, 8'h00, '0, '1);
      total++; if (q0 !== IV0) $display("FAIL rd_00: got %h want %h", q0, IV0); else passed++;
      op0(1'b0, 1'b1, 8'h7F, '0, '1);
      total++; if (q0 !== IV0) $display("FAIL rd_7f: got %h want %h", q0, IV0); else passed++;
      op0(1'b0, 1'b1, 8'hFF, '0, '1);
      total++; if (q0 !== IV0) $display("FAIL rd_ff: got %h want %h", q0, IV0); else passed++;
   endtask

   task automatic test_lane_write();
      op0(1'b0, 1'b0, 8'h10, 23'h7FFFFF, 23'h7FFF00);
      op0(1'b0, 1'b1, 8'h10, '0, '0);
      total++; if (q0 !== {IV0[22:8], 8'hFF}) $display("FAIL lane_write: got %h want %h", q0, {IV0[22:8], 8'hFF}); else passed++;
   endtask

   task automatic test_hold();
      op0(1'b0, 1'b1, 8'h10, '0, '1);
      total++; if (q0 !== exp0) $display("FAIL hold_rd: got %h want %h", q0, exp0); else passed++;
      for (int i = 0; i < 10; i++) begin
         op0(1'b1, 1'($urandom), 8'($urandom), 23'($urandom), 23'($urandom));
         total++; if (q0 !== {IV0[22:8], 8'hFF}) $display("FAIL hold_idle%0d: got %h want %h", i, q0, {IV0[22:8], 8'hFF}); else passed++;
      end
      op0(1'b0, 1'b0, 8'h10, 23'h0, 23'h0);
      total++; if (q0 !== {IV0[22:8], 8'hFF}) $display("FAIL hold_wr: got %h want %h", q0, {IV0[22:8], 8'hFF}); else passed++;
      op0(1'b0, 1'b1, 8'h10, '0, '1);
      total++; if (q0 !== 23'h0) $display("FAIL hold_newrd: got %h want 0", q0); else passed++;
   endtask

   task automatic test_reinit();
      int n;
      op0(1'b0, 1'b0, 8'h20, 23'h123, 23'h0);
      cen0 = 1'b0; gwen0 = 1'b1; a0 = 8'h20; init_req0 = 1'b1;
      step();
      init_req0 = 1'b0; cen0 = 1'b1;
      total++; if (q0 !== 23'h123) $display("FAIL reinit_rd: got %h want 123", q0); else passed++;
      total++; if (busy0 !== 1'b1) $display("FAIL reinit_busy: got %b want 1", busy0); else passed++;
      n = 0;
      while (busy0 && n < 1000) begin
         cen0 = !(n == 200 || n == 100); gwen0 = (n != 200);
         a0 = (n == 200) ? 8'h30 : 8'h20; d0 = 23'h7ABCD; wen0 = '0;
         init_req0 = (n == 150);
         step();
         n++;
      end
      cen0 = 1'b1; gwen0 = 1'b1; init_req0 = 1'b0;
      total++; if (n != 256) $display("FAIL reinit_len: got %0d want 256", n); else passed++;
      total++; if (q0 !== 23'h123) $display("FAIL reinit_q_held: got %h want 123", q0); else passed++;
      for (int i = 0; i < 256; i++) mem0[i] = IV0;
      op0(1'b0, 1'b1, 8'h20, '0, '1);
      total++; if (q0 !== IV0) $display("FAIL reinit_rd20: got %h want %h", q0, IV0); else passed++;
      op0(1'b0, 1'b1, 8'h30, '0, '1);
      total++; if (q0 !== IV0) $display("FAIL reinit_rd30: got %h want %h", q0, IV0); else passed++;
   endtask

   task automatic test_reset_mid_init();
      int n;
      op0(1'b0, 1'b0, 8'h44, 23'h1111, 23'h0);
      init_req0 = 1'b1;
      step();
      init_req0 = 1'b0;
      repeat (100) step();
      rst0 = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++; if (q0 !== 23'h0) $display("FAIL midrst_q%0d: got %h want 0", i, q0); else passed++;
         total++; if (busy0 !== 1'b1) $display("FAIL midrst_busy%0d: got %b want 1", i, busy0); else passed++;
         if (i < 2) step();
      end
      rst0 = 1'b0;
      wait_init(1'b0, n);
      total++; if (n != 256) $display("FAIL midrst_len: got %0d want 256", n); else passed++;
      for (int i = 0; i < 256; i++) mem0[i] = IV0;
      exp0 = '0;
      op0(1'b0, 1'b1, 8'h44, '0, '1);
      total++; if (q0 !== IV0) $display("FAIL midrst_rd: got %h want %h", q0, IV0); else passed++;
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 3);
         op0(r == 0, r == 1 ? 1'b0 : 1'b1, 8'($urandom), 23'($urandom),
             $urandom_range(0, 1) ? 23'h0 : 23'($urandom));
         total++; if (q0 !== exp0) $display("FAIL rand%0d: got %h want %h", i, q0, exp0); else passed++;
      end
   endtask

   task automatic test_outreg();
      int n;
      logic [63:0] old, d;
      rst1 = 1'b1;
      step();
      total++; if (q1 !== 64'h0) $display("FAIL or_reset_q: got %h want 0", q1); else passed++;
      total++; if (busy1 !== 1'b1) $display("FAIL or_reset_busy: got %b want 1", busy1); else passed++;
      rst1 = 1'b0;
      wait_init(1'b1, n);
      total++; if (n != 16) $display("FAIL or_init_len: got %0d want 16", n); else passed++;
      for (int i = 0; i < 16; i++) mem1[i] = IV1;
      for (int i = 0; i < 4; i++) op1(1'b0, 1'b0, 4'(i), {$urandom, $urandom}, 8'h00);
      op1(1'b0, 1'b1, 4'd0, '0, '1);
      total++; if (q1 !== 64'h0) $display("FAIL or_lat: got %h want 0", q1); else passed++;
      for (int i = 1; i <= 5; i++) begin
         op1(i < 4 ? 1'b0 : 1'b1, 1'b1, 4'(i), '0, '1);
         total++; if (q1 !== mem1[i < 4 ? i - 1 : 3]) $display("FAIL or_b2b%0d: got %h want %h", i, q1, mem1[i < 4 ? i - 1 : 3]); else passed++;
      end
      op1(1'b0, 1'b1, 4'd9, '0, '1);
      op1(1'b1, 1'b1, 4'd0, '0, '1);
      total++; if (q1 !== IV1) $display("FAIL or_init_val: got %h want %h", q1, IV1); else passed++;
      old = mem1[2];
      d = {$urandom, $urandom};
      op1(1'b0, 1'b0, 4'd2, d, 8'hFE);
      op1(1'b0, 1'b1, 4'd2, '0, '1);
      op1(1'b1, 1'b1, 4'd0, '0, '1);
      total++; if (q1 !== {old[63:8], d[7:0]}) $display("FAIL or_byte_wr: got %h want %h", q1, {old[63:8], d[7:0]}); else passed++;
   endtask

   initial begin
      rst0 = 1'b1; cen0 = 1'b1; gwen0 = 1'b1; init_req0 = 1'b0; a0 = '0; wen0 = '1; d0 = '0;
      rst1 = 1'b1; cen1 = 1'b1; gwen1 = 1'b1; init_req1 = 1'b0; a1 = '0; wen1 = '1; d1 = '0;
      exp0 = '0;
      test_reset();
      test_lane_write();
      test_hold();
      test_reinit();
      test_reset_mid_init();
      test_random();
      test_outreg();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
